// File: rtl/shift_rows_col_feeder_pkg.sv
// Shared constants, FSM encoding and byte/column helpers
// for the ShiftRows column feeder.
package shift_rows_col_feeder_pkg;

  localparam int STATE_W = 128;
  localparam int COL_W   = 32;
  localparam int BYTE_W  = 8;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EMIT = 1'b1
  } state_t;

  // LSB position of s(r,c); byte k = 4c+r sits at [127-8k -: 8]
  function automatic int byte_lsb(input int r, input int c);
    return STATE_W - BYTE_W * (4 * c + r) - BYTE_W;
  endfunction

  // Column c of a column-major state, row 0 in the MSBs
  function automatic logic [COL_W-1:0] col_of(
    input logic [STATE_W-1:0] s,
    input logic [1:0]         c
  );
    return s[STATE_W - 1 - COL_W * int'(c) -: COL_W];
  endfunction

endpackage

// File: rtl/shift_rows_col_feeder_if.sv
// Block-in / column-out handshake bundle.
// The feeder takes the slave side.
interface shift_rows_col_feeder_if;
  import shift_rows_col_feeder_pkg::*;

  logic [STATE_W-1:0] in_state;
  logic               in_final;
  logic               in_valid;
  logic               in_ready;
  logic [COL_W-1:0]   out_col;
  logic [1:0]         out_idx;
  logic               out_last;
  logic               out_final;
  logic               out_valid;
  logic               out_ready;

  modport master (
    output in_state, in_final, in_valid, out_ready,
    input  in_ready, out_col, out_idx, out_last,
    input  out_final, out_valid
  );

  modport slave (
    input  in_state, in_final, in_valid, out_ready,
    output in_ready, out_col, out_idx, out_last,
    output out_final, out_valid
  );

endinterface

// File: rtl/shift_rows_col_feeder_perm.sv
// Combinational ShiftRows / InvShiftRows byte permutation
// over a full column-major AES state.
module shift_rows_perm
  import shift_rows_col_feeder_pkg::*;
#(
  parameter bit INVERSE = 1'b0
) (
  input  logic [STATE_W-1:0] state,
  output logic [STATE_W-1:0] shifted
);

  // Row r rotates left by r (encrypt) or right by r (decrypt)
  always_comb begin
    int sc;
    shifted = '0;
    sc = 0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        if (INVERSE)
          sc = (c - r + 4) % 4;
        else
          sc = (c + r) % 4;
        shifted[byte_lsb(r, c) +: BYTE_W] =
          state[byte_lsb(r, sc) +: BYTE_W];
      end
    end
  end

endmodule

// File: rtl/shift_rows_col_feeder.sv
// Accepts a 128-bit state, applies (Inv)ShiftRows and
// streams it out one column per cycle toward mix_columns.
module shift_rows_col_feeder
  import shift_rows_col_feeder_pkg::*;
#(
  parameter bit INVERSE = 1'b0
) (
  input logic                    clk,
  input logic                    rst_n,
  shift_rows_col_feeder_if.slave bus
);

  state_t             st;
  logic [1:0]         col;
  logic [STATE_W-1:0] sbuf;
  logic [STATE_W-1:0] shifted;
  logic               in_ready;
  logic               accept;
  logic [COL_W-1:0]   col_q;
  logic [1:0]         idx_q;
  logic               last_q;
  logic               final_q;
  logic               valid_q;

  shift_rows_perm #(
    .INVERSE (INVERSE)
  ) u_perm (
    .state   (bus.in_state),
    .shifted (shifted)
  );

  // Refill allowed while idle or as the last column leaves
  assign in_ready = (st == ST_IDLE) ||
                    (st == ST_EMIT && col == 2'd3 &&
                     bus.out_ready);
  assign accept   = bus.in_valid && in_ready;

  assign bus.in_ready  = in_ready;
  assign bus.out_col   = col_q;
  assign bus.out_idx   = idx_q;
  assign bus.out_last  = last_q;
  assign bus.out_final = final_q;
  assign bus.out_valid = valid_q;

  // Block load, column stepping and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st      <= ST_IDLE;
      col     <= 2'd0;
      sbuf    <= '0;
      col_q   <= '0;
      idx_q   <= 2'd0;
      last_q  <= 1'b0;
      final_q <= 1'b0;
      valid_q <= 1'b0;
    end else if (accept) begin
      st      <= ST_EMIT;
      col     <= 2'd0;
      sbuf    <= shifted;
      col_q   <= col_of(shifted, 2'd0);
      idx_q   <= 2'd0;
      last_q  <= 1'b0;
      final_q <= bus.in_final;
      valid_q <= 1'b1;
    end else if (st == ST_EMIT && bus.out_ready) begin
      if (col == 2'd3) begin
        st      <= ST_IDLE;
        last_q  <= 1'b0;
        valid_q <= 1'b0;
      end else begin
        col    <= col + 2'd1;
        col_q  <= col_of(sbuf, col + 2'd1);
        idx_q  <= col + 2'd1;
        last_q <= (col == 2'd2);
      end
    end
  end

endmodule
